srt_div_arbiter: RTL and testbench
==================================

// Module: srt_div_arbiter
// PURPOSE
//  Shares one srt_4_div instance between NREQ requesters. Round-robin arbitration, one division in flight.
//  Sequences the divider's start/finish protocol. Returns results on a single tagged response channel.
//  Patches the divide-by-zero result and guards the divider with a watchdog. Sits between core-side
//  requesters and the divider, inside the integer-execute cluster.
// PARAMETERS
//  DW      32  operand/result width; must equal srt_4_div DW
//  NREQ    4   number of requesters, 2..8
//  IDW     2   requester-id width, = clog2(NREQ)
//  TMO     40  watchdog limit in WAIT cycles; must be > worst-case divider latency (~20)
// PORTS
//  clk            in   1         clock, rising edge
//  rst_n          in   1         asynchronous active-low reset
//  req_valid      in   NREQ      per-requester request valid
//  req_ready      out  NREQ      one-hot accept pulse; request taken when valid&ready
//  req_dividend   in   NREQ*DW   packed dividends, requester i at [i*DW +: DW]
//  req_divisor    in   NREQ*DW   packed divisors, same packing
//  rsp_valid      out  1         response valid, held until rsp_ready
//  rsp_ready      in   1         response consumer ready
//  rsp_id         out  IDW       requester index of the response
//  rsp_quotient   out  DW        quotient
//  rsp_remainder  out  DW        remainder
//  rsp_error      out  2         00 ok, 01 divide-by-zero, 10 watchdog timeout
//  div_start      out  1         to srt_4_div start
//  div_dividend   out  DW        to srt_4_div dividend
//  div_divisor    out  DW        to srt_4_div divisor
//  div_quotient   in   DW        from srt_4_div quotient
//  div_reminder   in   DW        from srt_4_div reminder
//  div_finish     in   1         from srt_4_div divfinish, one-cycle pulse
//  div_error      in   1         from srt_4_div diverror, valid when div_finish=1
//  busy           out  1         high in any state other than IDLE
// BEHAVIOUR
//  - Reset: state IDLE, rr pointer 0. All outputs 0: req_ready, rsp_*, div_*, busy.
//  - FSM states are IDLE, ISSUE, WAIT, RESP.
//  - IDLE:
//    - If any req_valid: grant = first valid index at or after rr pointer, searching modulo NREQ.
//    - req_ready[grant]=1 combinationally in this same cycle.
//    - Latch operands and grant id into op registers, then go to ISSUE.
//    - With no req_valid, stay in IDLE.
//  - ISSUE: div_start=1 for exactly one cycle, operands driven from op registers. Go to WAIT.
//  - div_dividend/div_divisor are registered and held stable from ISSUE until the next grant.
//  - WAIT: the watchdog counts from 0.
//    - On div_finish, capture the result and go to RESP.
//    - If div_error=1: rsp_quotient={DW{1'b1}}, rsp_remainder=latched dividend, rsp_error=01.
//    - If div_error=0: pass through div_quotient/div_reminder, rsp_error=00.
//    - If the count reaches TMO-1 with no finish: quotient=0, remainder=0, rsp_error=10, go to RESP.
//      busy stays asserted. A later div_finish is ignored in every state except WAIT.
//  - RESP: rsp_valid=1 with stable data until rsp_ready.
//    - On the handshake: rr pointer = (grant+1) mod NREQ, go to IDLE.
//  - Requests arriving while busy get req_ready=0 and must hold.
//  - Simultaneous rsp handshake and pending req_valid: the next grant happens in the following IDLE
//    cycle (one bubble).
//  - Latency from accept to rsp_valid = divider latency + 2 cycles. Divider latency is start to
//    divfinish, including its 16-cycle hold for short or zero-divisor operations.
//  - The controller never asserts div_start outside ISSUE. At most one operation is in flight.
//  - rst_n mid-operation: everything returns to reset values asynchronously. No response is issued
//    for the aborted request. The divider shares rst_n.
//  - Unsigned operands only, no width conversion. dividend=0 is forwarded normally.
// STRUCTURE
//  - Shared package/header srt_div_pkg: state encodings (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3),
//    rsp_error codes, TMO default.
//  - Sub-module rr_arbiter (NREQ): inputs req vector, pointer, enable; outputs one-hot grant and
//    binary grant index. Purely combinational. Pointer register stays in srt_div_arbiter.
//  - srt_4_div is instantiated by the parent, not inside this block.
// TESTING (bench instantiates srt_4_div + srt_div_arbiter, DW=32, NREQ=4)
//  1. Req0 100/7, rsp_ready=1 -> one rsp: id=0, q=14, r=2, err=00. div_start pulsed exactly once.
//  2. All four valid, ops (i+1)*1000/3 -> rsp ids in order 0,1,2,3. Each req_ready is a one-cycle
//     pulse. Values 333r1, 666r2, 1000r0, 1333r1.
//  3. Req2 0xDEAD/0 -> id=2, q=0xFFFFFFFF, r=0xDEAD, err=01.
//  4. Divider model with div_finish tied 0 -> after TMO WAIT cycles: rsp err=10, q=0, r=0. FSM then
//     returns to IDLE.
//  5. rsp_ready held 0 for 10 cycles -> rsp_valid and data stable. req1 pending is not accepted until
//     one cycle after the handshake.
//  6. rst_n pulsed low in WAIT -> busy=0, rsp_valid=0, div_start=0 at once. Next request completes
//     correctly.

Source files
------------

// File: rtl/srt_div_pkg.sv
// Shared definitions for the SRT divider arbiter: FSM state encoding,
// response error codes and the default watchdog limit.
package srt_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ERR_OK   = 2'b00,
        ERR_DIV0 = 2'b01,
        ERR_TMO  = 2'b10
    } rsp_err_e;

    // Watchdog limit in WAIT cycles; must exceed the worst divider latency.
    localparam int unsigned TMO_DEFAULT = 40;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection, purely combinational.
// Ports:
//   req       request vector
//   ptr       highest-priority index for this decision
//   en        when low, no grant is produced
//   grant     one-hot grant (all zero when nothing granted)
//   grant_idx binary index of the granted requester
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    logic        found;
    int unsigned idx;

    // First requester at or after ptr, searching modulo NREQ.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (en && !found && req[idx[IDW-1:0]]) begin
                found                  = 1'b1;
                grant[idx[IDW-1:0]]    = 1'b1;
                grant_idx              = idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/srt_div_arbiter.sv
// Shares one srt_4_div between NREQ requesters with round-robin arbitration
// and one division in flight. Sequences start/finish, patches divide-by-zero
// results, guards the divider with a watchdog and returns tagged responses.
// Ports:
//   req_valid/req_ready/req_dividend/req_divisor  requester side (packed per index)
//   rsp_valid/rsp_ready/rsp_id/rsp_quotient/rsp_remainder/rsp_error  response channel
//   div_start/div_dividend/div_divisor            to the divider
//   div_quotient/div_reminder/div_finish/div_error from the divider
//   busy                                           high whenever not IDLE
module srt_div_arbiter
    import srt_div_pkg::*;
#(
    parameter int unsigned DW   = 32,
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2,
    parameter int unsigned TMO  = TMO_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*DW-1:0] req_dividend,
    input  logic [NREQ*DW-1:0] req_divisor,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [DW-1:0]      rsp_quotient,
    output logic [DW-1:0]      rsp_remainder,
    output logic [1:0]         rsp_error,
    output logic               div_start,
    output logic [DW-1:0]      div_dividend,
    output logic [DW-1:0]      div_divisor,
    input  logic [DW-1:0]      div_quotient,
    input  logic [DW-1:0]      div_reminder,
    input  logic               div_finish,
    input  logic               div_error,
    output logic               busy
);

    localparam int unsigned CW = (TMO > 1) ? $clog2(TMO) : 1;

    state_e          state_q, state_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [IDW-1:0]  id_d;
    logic [DW-1:0]   dvd_d, dvs_d;
    logic            start_d;
    logic            busy_d;
    logic            rsp_valid_d;
    logic [DW-1:0]   rsp_q_d, rsp_r_d;
    logic [1:0]      rsp_err_d;
    logic [CW-1:0]   wd_q, wd_d;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            arb_en;

    // Arbitration only happens while IDLE; req_ready is the grant itself.
    assign arb_en = (state_q == ST_IDLE);

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_q),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        id_d        = rsp_id;
        dvd_d       = div_dividend;
        dvs_d       = div_divisor;
        start_d     = 1'b0;
        wd_d        = wd_q;
        rsp_valid_d = rsp_valid;
        rsp_q_d     = rsp_quotient;
        rsp_r_d     = rsp_remainder;
        rsp_err_d   = rsp_error;

        unique case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    id_d    = grant_idx;
                    dvd_d   = req_dividend[32'(grant_idx) * DW +: DW];
                    dvs_d   = req_divisor[32'(grant_idx) * DW +: DW];
                    start_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wd_d    = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A finish in the last watchdog cycle still wins over timeout.
                if (div_finish) begin
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                    if (div_error) begin
                        rsp_q_d   = {DW{1'b1}};
                        rsp_r_d   = div_dividend;
                        rsp_err_d = ERR_DIV0;
                    end else begin
                        rsp_q_d   = div_quotient;
                        rsp_r_d   = div_reminder;
                        rsp_err_d = ERR_OK;
                    end
                end else if (wd_q == CW'(TMO - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_q_d     = '0;
                    rsp_r_d     = '0;
                    rsp_err_d   = ERR_TMO;
                    state_d     = ST_RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_d        = (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rr_q          <= '0;
            wd_q          <= '0;
            rsp_id        <= '0;
            div_dividend  <= '0;
            div_divisor   <= '0;
            div_start     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_error     <= '0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            wd_q          <= wd_d;
            rsp_id        <= id_d;
            div_dividend  <= dvd_d;
            div_divisor   <= dvs_d;
            div_start     <= start_d;
            rsp_valid     <= rsp_valid_d;
            rsp_quotient  <= rsp_q_d;
            rsp_remainder <= rsp_r_d;
            rsp_error     <= rsp_err_d;
            busy          <= busy_d;
        end
    end

endmodule

// File: tb/tb_srt_div_arbiter.sv
// Bench for srt_div_arbiter with a behavioural divider stand-in and a
// scoreboard that predicts grants and results from plain arithmetic.
`timescale 1ns/1ps
module tb_srt_div_arbiter;

    localparam int unsigned DW   = 32;
    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;
    localparam int unsigned TMO  = 40;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_dividend = '0;
    logic [NREQ*DW-1:0] req_divisor = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b1;
    logic [IDW-1:0]     rsp_id;
    logic [DW-1:0]      rsp_quotient, rsp_remainder;
    logic [1:0]         rsp_error;
    logic               div_start;
    logic [DW-1:0]      div_dividend, div_divisor;
    logic [DW-1:0]      div_quotient, div_reminder;
    logic               div_finish, div_error;
    logic               busy;

    always #5 clk = ~clk;

    srt_div_arbiter #(.DW(DW), .NREQ(NREQ), .IDW(IDW), .TMO(TMO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_error     (rsp_error),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_reminder  (div_reminder),
        .div_finish    (div_finish),
        .div_error     (div_error),
        .busy          (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- divider stand-in ----------------
    bit            hang = 1'b0;
    int            m_cnt;
    bit            m_busy;
    logic [DW-1:0] m_a, m_b;

    function automatic int div_lat(input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (b == 0 || a < b) return 16;
        return 17 + int'(a % 4);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy       <= 1'b0;
            m_cnt        <= 0;
            m_a          <= '0;
            m_b          <= '0;
            div_finish   <= 1'b0;
            div_error    <= 1'b0;
            div_quotient <= '0;
            div_reminder <= '0;
        end else begin
            div_finish <= 1'b0;
            if (div_start) begin
                m_a    <= div_dividend;
                m_b    <= div_divisor;
                m_busy <= 1'b1;
                m_cnt  <= hang ? 60 : div_lat(div_dividend, div_divisor) - 1;
            end else if (m_busy) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_busy       <= 1'b0;
                    div_finish   <= 1'b1;
                    div_error    <= (m_b == 0);
                    div_quotient <= (m_b == 0) ? 32'h1234_5678 : m_a / m_b;
                    div_reminder <= (m_b == 0) ? 32'h0000_0BAD : m_a % m_b;
                end
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        logic [IDW-1:0] id;
        logic [DW-1:0]  q;
        logic [DW-1:0]  r;
        logic [1:0]     err;
    } exp_t;

    exp_t sb[$];
    int   m_rr = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   last_lat = 0;
    int   start_cnt = 0;
    logic rsp_valid_prev = 1'b0;

    initial begin : monitor
        logic [NREQ-1:0] acc;
        logic [DW-1:0]   a, b;
        exp_t            e;
        int              exp_i, idx;
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (!rst_n) begin
                sb.delete();
                m_rr = 0;
                rsp_valid_prev = 1'b0;
            end else begin
                if (div_start) start_cnt++;
                acc = req_valid & req_ready;
                if (acc != 0) begin
                    exp_i = -1;
                    for (int k = 0; k < int'(NREQ); k++) begin
                        idx = (m_rr + k) % int'(NREQ);
                        if (exp_i < 0 && req_valid[idx]) exp_i = idx;
                    end
                    check("accept_onehot", 64'($onehot(acc)), 64'd1);
                    check("accept_grant", 64'(req_ready), 64'(1) << exp_i);
                    check("accept_not_busy", 64'(busy), 64'd0);
                    a = req_dividend[exp_i*DW +: DW];
                    b = req_divisor[exp_i*DW +: DW];
                    e.id = IDW'(exp_i);
                    if (hang) begin
                        e.q = '0; e.r = '0; e.err = 2'b10;
                    end else if (b == 0) begin
                        e.q = '1; e.r = a; e.err = 2'b01;
                    end else begin
                        e.q = a / b; e.r = a % b; e.err = 2'b00;
                    end
                    sb.push_back(e);
                    acc_cyc = cyc;
                end
                if (rsp_valid && !rsp_valid_prev) last_lat = cyc - acc_cyc;
                if (rsp_valid && rsp_ready) begin
                    if (sb.size() == 0) begin
                        check("rsp_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("sb_id", 64'(rsp_id), 64'(e.id));
                        check("sb_quotient", 64'(rsp_quotient), 64'(e.q));
                        check("sb_remainder", 64'(rsp_remainder), 64'(e.r));
                        check("sb_error", 64'(rsp_error), 64'(e.err));
                        m_rr = (int'(e.id) + 1) % int'(NREQ);
                    end
                end
                rsp_valid_prev = rsp_valid;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        rst_n        = 1'b0;
        req_valid    = '0;
        req_dividend = '0;
        req_divisor  = '0;
        rsp_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", 64'({rsp_id, rsp_error, rsp_quotient | rsp_remainder}), 64'd0);
        check("rst_div_out", 64'({div_start, div_dividend | div_divisor}), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One request on requester id; returns the response fields.
    task automatic do_single(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             output logic [IDW-1:0] rid, output logic [DW-1:0] q,
                             output logic [DW-1:0] r, output logic [1:0] err);
        int n;
        rid = '1; q = 'x; r = 'x; err = 'x;
        req_dividend[id*DW +: DW] = a;
        req_divisor[id*DW +: DW]  = b;
        req_valid[id] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[id] && n < 50);
        if (!req_ready[id]) check("single_accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 100);
        if (!rsp_valid) check("single_rsp_timeout", 64'd0, 64'd1);
        rid = rsp_id; q = rsp_quotient; r = rsp_remainder; err = rsp_error;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int            id;
        logic [DW-1:0] a, b, q, r;
        logic [1:0]    err;
    } vec_t;

    vec_t tab[6];

    initial begin : fail_safe
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        logic [IDW-1:0]  rid;
        logic [DW-1:0]   q, r;
        logic [1:0]      err;
        logic [NREQ-1:0] acc;
        logic [IDW-1:0]  ids[4];
        logic [DW-1:0]   qs[4], rs[4];
        int              rdy_hi[4];
        int              got, n, s0, seen, unstable, early;
        logic [63:0]     snap;
        logic [DW-1:0]   a, b;

        tab[0] = '{0, 32'd100,         32'd7,    32'd14,         32'd2,      2'b00};
        tab[1] = '{2, 32'h0000_DEAD,   32'd0,    32'hFFFF_FFFF,  32'hDEAD,   2'b01};
        tab[2] = '{1, 32'd0,           32'd5,    32'd0,          32'd0,      2'b00};
        tab[3] = '{3, 32'hFFFF_FFFF,   32'd1,    32'hFFFF_FFFF,  32'd0,      2'b00};
        tab[4] = '{1, 32'd5,           32'd9,    32'd0,          32'd5,      2'b00};
        tab[5] = '{3, 32'd12345678,    32'd1000, 32'd12345,      32'd678,    2'b00};

        do_reset();

        // Vector table, single requests with rsp_ready held high.
        for (int t = 0; t < 6; t++) begin
            s0 = start_cnt;
            do_single(tab[t].id, tab[t].a, tab[t].b, rid, q, r, err);
            check($sformatf("vec%0d_id", t), 64'(rid), 64'(tab[t].id));
            check($sformatf("vec%0d_q", t), 64'(q), 64'(tab[t].q));
            check($sformatf("vec%0d_r", t), 64'(r), 64'(tab[t].r));
            check($sformatf("vec%0d_err", t), 64'(err), 64'(tab[t].err));
            if (t == 0) begin
                check("vec0_start_pulses", 64'(start_cnt - s0), 64'd1);
                check("vec0_latency", 64'(last_lat), 64'(div_lat(32'd100, 32'd7) + 2));
            end
        end

        // All four requesters at once: round-robin order 0..3.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_dividend[i*DW +: DW] = DW'((i + 1) * 1000);
            req_divisor[i*DW +: DW]  = 32'd3;
            rdy_hi[i] = 0;
        end
        req_valid = '1;
        got = 0;
        n = 0;
        while (got < 4 && n < 400) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < 4; i++) if (req_ready[i]) rdy_hi[i]++;
            acc = req_valid & req_ready;
            if (rsp_valid) begin
                ids[got] = rsp_id; qs[got] = rsp_quotient; rs[got] = rsp_remainder;
                got++;
            end
            @(posedge clk);
            #1;
            req_valid = req_valid & ~acc;
        end
        check("all4_count", 64'(got), 64'd4);
        for (int i = 0; i < 4 && i < got; i++) begin
            check($sformatf("all4_id%0d", i), 64'(ids[i]), 64'(i));
            check($sformatf("all4_q%0d", i), 64'(qs[i]), 64'(((i + 1) * 1000) / 3));
            check($sformatf("all4_r%0d", i), 64'(rs[i]), 64'(((i + 1) * 1000) % 3));
            check($sformatf("all4_ready_pulse%0d", i), 64'(rdy_hi[i]), 64'd1);
        end

        // Watchdog: divider never finishes in time; the late finish is ignored.
        hang = 1'b1;
        do_single(1, 32'd100, 32'd3, rid, q, r, err);
        hang = 1'b0;
        check("tmo_err", 64'(err), 64'd2);
        check("tmo_q", 64'(q), 64'd0);
        check("tmo_r", 64'(r), 64'd0);
        check("tmo_latency", 64'(last_lat), 64'(TMO + 2));
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid || busy) seen++;
        end
        check("tmo_stale_finish_ignored", 64'(seen), 64'd0);
        @(posedge clk);
        #1;

        // Back-pressure: response held stable, req1 waits for the bubble.
        rsp_ready = 1'b0;
        req_dividend[0*DW +: DW] = 32'd50;
        req_divisor[0*DW +: DW]  = 32'd7;
        req_valid[0] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[0] && n < 50);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        req_dividend[1*DW +: DW] = 32'd77;
        req_divisor[1*DW +: DW]  = 32'd5;
        req_valid[1] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 100);
        snap = {rsp_id, rsp_error, rsp_quotient[29:0], rsp_remainder};
        check("bp_q", 64'(rsp_quotient), 64'd7);
        check("bp_r", 64'(rsp_remainder), 64'd1);
        unstable = 0;
        early = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || {rsp_id, rsp_error, rsp_quotient[29:0], rsp_remainder} !== snap)
                unstable++;
            if (req_ready[1]) early++;
        end
        check("bp_stable", 64'(unstable), 64'd0);
        check("bp_req1_held_off", 64'(early), 64'd0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_handshake_valid", 64'(rsp_valid), 64'd1);
        check("bp_handshake_req1_ready", 64'(req_ready[1]), 64'd0);
        @(negedge clk);
        check("bp_bubble_req1_ready", 64'(req_ready[1]), 64'd1);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        n = 0;
        while ((busy || sb.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_drain", 64'(busy || sb.size() != 0), 64'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset while WAITing, then a clean transaction.
        req_dividend[3*DW +: DW] = 32'd1000;
        req_divisor[3*DW +: DW]  = 32'd7;
        req_valid[3] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[3] && n < 50);
        @(posedge clk);
        #1;
        req_valid[3] = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("arst_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("arst_div_start", 64'(div_start), 64'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_single(2, 32'd81, 32'd9, rid, q, r, err);
        check("arst_next_id", 64'(rid), 64'd2);
        check("arst_next_q", 64'(q), 64'd9);
        check("arst_next_r", 64'(r), 64'd0);
        check("arst_next_err", 64'(err), 64'd0);

        // Random traffic against the scoreboard.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~acc;
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] && $urandom_range(3) == 0) begin
                    a = ($urandom_range(7) == 0) ? 32'd0 : DW'($urandom);
                    case ($urandom_range(3))
                        0:       b = 32'd0;
                        1:       b = DW'($urandom_range(1, 15));
                        2:       b = DW'($urandom);
                        default: b = a >> $urandom_range(0, 8);
                    endcase
                    req_dividend[i*DW +: DW] = a;
                    req_divisor[i*DW +: DW]  = b;
                    req_valid[i] = 1'b1;
                end
            end
            rsp_ready = ($urandom_range(9) < 7);
        end
        n = 0;
        while ((req_valid != 0 || busy || sb.size() != 0) && n < 500) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~acc;
            rsp_ready = 1'b1;
            n++;
        end
        check("rand_drain", 64'(req_valid != 0 || busy || sb.size() != 0), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
